// File: rtl/spi_regs_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spi_regs_pkg
// Description : Register map and FSM encoding shared by the register-bank
//               arbiter and its sub-blocks.
// Revision    : 1.0 - initial release
// ============================================================================
package spi_regs_pkg;

    localparam int NUM_REGS         = 5;
    localparam int ADDR_EN_OUT_7_0  = 0;
    localparam int ADDR_EN_OUT_15_8 = 1;
    localparam int ADDR_EN_PWM_7_0  = 2;
    localparam int ADDR_EN_PWM_15_8 = 3;
    localparam int ADDR_PWM_DUTY    = 4;

    // OWN states are one-hot so the state register doubles as the grant vector.
    localparam int         ST_W    = 2;
    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_OWN0 = 2'b01;
    localparam logic [1:0] ST_OWN1 = 2'b10;

    function automatic logic [ST_W-1:0] own_state(input logic port);
        return port ? ST_OWN1 : ST_OWN0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/reg_bank_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : reg_bank_arbiter_if
// Description : Two write-request ports (valid/lock/addr/data with ready).
// Revision    : 1.0 - initial release
// ============================================================================
interface reg_bank_arbiter_if #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 8
);
    logic              wr_valid_0;
    logic              wr_lock_0;
    logic [ADDR_W-1:0] wr_addr_0;
    logic [DATA_W-1:0] wr_data_0;
    logic              wr_ready_0;

    logic              wr_valid_1;
    logic              wr_lock_1;
    logic [ADDR_W-1:0] wr_addr_1;
    logic [DATA_W-1:0] wr_data_1;
    logic              wr_ready_1;

    modport master (
        output wr_valid_0, wr_lock_0, wr_addr_0, wr_data_0,
        output wr_valid_1, wr_lock_1, wr_addr_1, wr_data_1,
        input  wr_ready_0, wr_ready_1
    );

    modport slave (
        input  wr_valid_0, wr_lock_0, wr_addr_0, wr_data_0,
        input  wr_valid_1, wr_lock_1, wr_addr_1, wr_data_1,
        output wr_ready_0, wr_ready_1
    );
endinterface
`default_nettype wire

// File: rtl/rr_arbiter_2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter_2
// Description : Two-way round-robin pick; pointer moves to the non-yielding port.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter_2 (
    input  wire logic       clk,
    input  wire logic       rst,
    input  wire logic [1:0] i_req,
    input  wire logic       i_advance,
    input  wire logic       i_yield_port,
    output logic            o_pick,
    output logic            o_any
);
    logic r_ptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= 1'b0;
        end else if (i_advance) begin
            r_ptr <= ~i_yield_port;
        end
    end

    assign o_any  = |i_req;
    assign o_pick = (&i_req) ? r_ptr : i_req[1];
endmodule
`default_nettype wire

// File: rtl/reg_bank_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : reg_bank_arbiter
// Description : Five-byte configuration bank shared by two write ports with
//               round-robin arbitration and bounded locked bursts.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_bank_arbiter
    import spi_regs_pkg::*;
#(
    parameter int ADDR_W    = 7,
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 4
) (
    input  wire logic        clk,
    input  wire logic        rst,
    reg_bank_arbiter_if.slave bus,
    output logic [DATA_W-1:0] en_reg_out_7_0,
    output logic [DATA_W-1:0] en_reg_out_15_8,
    output logic [DATA_W-1:0] en_reg_pwm_7_0,
    output logic [DATA_W-1:0] en_reg_pwm_15_8,
    output logic [DATA_W-1:0] pwm_duty_cycle,
    output logic [1:0]        grant,
    output logic              addr_err
);
    localparam int               CNT_W      = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(MAX_BURST - 1);

    logic [ST_W-1:0]   r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_regs [NUM_REGS];
    logic              r_addr_err;

    logic              w_own0, w_own1, w_rdy0, w_rdy1, w_commit;
    logic              w_lock, w_end_own, w_pick, w_any;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_data;

    assign w_own0   = (r_state == ST_OWN0);
    assign w_own1   = (r_state == ST_OWN1);
    assign w_rdy0   = !rst && w_own0 && bus.wr_valid_0;
    assign w_rdy1   = !rst && w_own1 && bus.wr_valid_1;
    assign w_commit = w_rdy0 || w_rdy1;
    assign w_addr   = w_own1 ? bus.wr_addr_1 : bus.wr_addr_0;
    assign w_data   = w_own1 ? bus.wr_data_1 : bus.wr_data_0;
    assign w_lock   = w_own1 ? bus.wr_lock_1 : bus.wr_lock_0;

    // Ownership ends on a missing request, an unlocked write, or the last burst slot.
    assign w_end_own = (w_own0 || w_own1) &&
                       !(w_commit && w_lock && (r_cnt < C_CNT_LAST));

    rr_arbiter_2 u_rr (
        .clk          (clk),
        .rst          (rst),
        .i_req        ({bus.wr_valid_1, bus.wr_valid_0}),
        .i_advance    (w_end_own),
        .i_yield_port (w_own1),
        .o_pick       (w_pick),
        .o_any        (w_any)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_addr_err <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
        end else begin
            r_addr_err <= w_commit && (w_addr >= ADDR_W'(NUM_REGS));
            for (int i = 0; i < NUM_REGS; i++) begin
                if (w_commit && (w_addr == ADDR_W'(i))) r_regs[i] <= w_data;
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_any) r_state <= own_state(w_pick);
                end
                ST_OWN0, ST_OWN1: begin
                    if (w_end_own) begin
                        r_state <= ST_IDLE;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign bus.wr_ready_0   = w_rdy0;
    assign bus.wr_ready_1   = w_rdy1;
    assign grant            = r_state;
    assign addr_err         = r_addr_err;
    assign en_reg_out_7_0   = r_regs[ADDR_EN_OUT_7_0];
    assign en_reg_out_15_8  = r_regs[ADDR_EN_OUT_15_8];
    assign en_reg_pwm_7_0   = r_regs[ADDR_EN_PWM_7_0];
    assign en_reg_pwm_15_8  = r_regs[ADDR_EN_PWM_15_8];
    assign pwm_duty_cycle   = r_regs[ADDR_PWM_DUTY];
endmodule
`default_nettype wire

// File: tb/tb_reg_bank_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_bank_arbiter
// Description : Randomized and directed bench for reg_bank_arbiter, checked
//               every cycle against a transaction-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_bank_arbiter;
    localparam int AW = 7;
    localparam int DW = 8;
    localparam int MB = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    reg_bank_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    logic [DW-1:0] o0, o1, p0, p1, duty;
    logic [1:0]    grant;
    logic          addr_err;

    reg_bank_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MB)) dut (
        .clk             (clk),
        .rst             (rst),
        .bus             (bus.slave),
        .en_reg_out_7_0  (o0),
        .en_reg_out_15_8 (o1),
        .en_reg_pwm_7_0  (p0),
        .en_reg_pwm_15_8 (p1),
        .pwm_duty_cycle  (duty),
        .grant           (grant),
        .addr_err        (addr_err)
    );

    int errors = 0;
    int checks = 0;

    // Transaction-level model: who owns the bank, how many writes it has made,
    // which port wins a tie, and the register contents.
    int          owner  = 0;
    int          nwr    = 0;
    int          favour = 0;
    logic [7:0]  mregs [5];
    bit          maerr  = 1'b0;
    bit          rdy_seen [2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        owner = 0; nwr = 0; favour = 0; maerr = 1'b0;
        for (int i = 0; i < 5; i++) mregs[i] = 8'h00;
    endtask

    // Compare DUT against the model for the current cycle, then advance the model.
    task automatic settle();
        logic       vv [2];
        logic       lk [2];
        logic [6:0] ad [2];
        logic [7:0] dt [2];
        logic [7:0] dr [5];
        logic       er0, er1;
        logic [1:0] eg;
        int         p;
        #1;
        vv[0] = bus.wr_valid_0; lk[0] = bus.wr_lock_0; ad[0] = bus.wr_addr_0; dt[0] = bus.wr_data_0;
        vv[1] = bus.wr_valid_1; lk[1] = bus.wr_lock_1; ad[1] = bus.wr_addr_1; dt[1] = bus.wr_data_1;
        dr[0] = o0; dr[1] = o1; dr[2] = p0; dr[3] = p1; dr[4] = duty;
        er0 = !rst && owner == 1 && vv[0];
        er1 = !rst && owner == 2 && vv[1];
        eg  = (owner == 1) ? 2'b01 : (owner == 2) ? 2'b10 : 2'b00;
        chk("ready_0", {31'd0, bus.wr_ready_0}, {31'd0, er0});
        chk("ready_1", {31'd0, bus.wr_ready_1}, {31'd0, er1});
        chk("grant", {30'd0, grant}, {30'd0, eg});
        chk("addr_err", {31'd0, addr_err}, {31'd0, maerr});
        for (int i = 0; i < 5; i++) chk($sformatf("reg%0d", i), {24'd0, dr[i]}, {24'd0, mregs[i]});
        rdy_seen[0] = er0;
        rdy_seen[1] = er1;
        if (rst) begin
            model_reset();
        end else if (owner == 0) begin
            maerr = 1'b0;
            if (vv[0] && vv[1]) owner = favour + 1;
            else if (vv[0])     owner = 1;
            else if (vv[1])     owner = 2;
        end else begin
            p = owner - 1;
            if (vv[p]) begin
                if (ad[p] < 7'd5) mregs[ad[p]] = dt[p];
                maerr = (ad[p] >= 7'd5);
                nwr++;
            end else begin
                maerr = 1'b0;
            end
            if (!(vv[p] && lk[p] && nwr < MB)) begin
                owner = 0; nwr = 0; favour = 1 - p;
            end
        end
    endtask

    task automatic adv();
        @(negedge clk);
    endtask

    task automatic cyc();
        settle();
        adv();
    endtask

    task automatic req(input int p, input bit lock, input logic [6:0] a, input logic [7:0] d);
        if (p == 0) begin
            bus.wr_valid_0 = 1'b1; bus.wr_lock_0 = lock; bus.wr_addr_0 = a; bus.wr_data_0 = d;
        end else begin
            bus.wr_valid_1 = 1'b1; bus.wr_lock_1 = lock; bus.wr_addr_1 = a; bus.wr_data_1 = d;
        end
    endtask

    task automatic drop(input int p);
        if (p == 0) begin bus.wr_valid_0 = 1'b0; bus.wr_lock_0 = 1'b0; end
        else        begin bus.wr_valid_1 = 1'b0; bus.wr_lock_1 = 1'b0; end
    endtask

    // Run n cycles, releasing each port as soon as its write is accepted.
    task automatic run_drop(input int n);
        for (int k = 0; k < n; k++) begin
            cyc();
            for (int p = 0; p < 2; p++) if (rdy_seen[p]) drop(p);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; drop(0); drop(1);
        cyc(); cyc();
        rst = 1'b0;
    endtask

    int r1q[$];
    int r0q[$];

    initial begin
        drop(0); drop(1);
        bus.wr_addr_0 = '0; bus.wr_data_0 = '0; bus.wr_addr_1 = '0; bus.wr_data_1 = '0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        model_reset();

        // Reset state
        settle();
        chk("rst_grant", {30'd0, grant}, 32'd0);
        chk("rst_ready0", {31'd0, bus.wr_ready_0}, 32'd0);
        chk("rst_duty", {24'd0, duty}, 32'd0);
        adv();
        rst = 1'b0;

        // Single write: ready one cycle after valid, register one cycle later
        req(0, 1'b0, 7'd4, 8'h80);
        settle(); chk("t1_ready_early", {31'd0, bus.wr_ready_0}, 32'd0); adv();
        settle(); chk("t1_ready", {31'd0, bus.wr_ready_0}, 32'd1); adv();
        drop(0);
        settle(); chk("t1_duty", {24'd0, duty}, 32'h80); chk("t1_o0", {24'd0, o0}, 32'h0); adv();

        // Simultaneous requests from reset
        do_reset();
        req(0, 1'b0, 7'd0, 8'h11); req(1, 1'b0, 7'd1, 8'h22);
        cyc();
        settle(); chk("t2_ready0", {31'd0, bus.wr_ready_0}, 32'd1); adv(); drop(0);
        settle(); chk("t2_gap", {31'd0, bus.wr_ready_1}, 32'd0); adv();
        settle(); chk("t2_ready1", {31'd0, bus.wr_ready_1}, 32'd1); adv(); drop(1);
        settle(); chk("t2_o0", {24'd0, o0}, 32'h11); chk("t2_o1", {24'd0, o1}, 32'h22); adv();

        // Locked burst of six on port 1 with port 0 waiting
        do_reset();
        req(1, 1'b1, 7'd2, 8'h01);
        for (int c = 0; c < 20; c++) begin
            settle();
            if (bus.wr_ready_1) r1q.push_back(c);
            if (bus.wr_ready_0) r0q.push_back(c);
            adv();
            if (c == 0) req(0, 1'b0, 7'd3, 8'h55);
            if (rdy_seen[1]) begin
                if (bus.wr_data_1 < 8'h06) bus.wr_data_1 = bus.wr_data_1 + 8'h01;
                else drop(1);
            end
            if (rdy_seen[0]) drop(0);
        end
        chk("t3_n1", r1q.size(), 32'd6);
        chk("t3_n0", r0q.size(), 32'd1);
        if (r1q.size() == 6 && r0q.size() == 1) begin
            chk("t3_b1_first", r1q[0], 32'd1);
            chk("t3_b1_last", r1q[3], 32'd4);
            chk("t3_p0_turn", r0q[0], 32'd6);
            chk("t3_b1_resume", r1q[4], 32'd8);
        end
        chk("t3_pwm0", {24'd0, p0}, 32'h06);
        chk("t3_pwm1", {24'd0, p1}, 32'h55);

        // Out-of-range address
        req(0, 1'b0, 7'd9, 8'hFF);
        cyc();
        settle(); chk("t4_ready", {31'd0, bus.wr_ready_0}, 32'd1); chk("t4_err_pre", {31'd0, addr_err}, 32'd0); adv();
        drop(0);
        settle(); chk("t4_err", {31'd0, addr_err}, 32'd1); adv();
        settle(); chk("t4_err_post", {31'd0, addr_err}, 32'd0); chk("t4_pwm0", {24'd0, p0}, 32'h06); adv();

        // Reset in the middle of a locked burst
        req(0, 1'b1, 7'd1, 8'h33);
        cyc(); cyc();
        bus.wr_data_0 = 8'h44;
        rst = 1'b1;
        settle(); chk("t5_ready_rst", {31'd0, bus.wr_ready_0}, 32'd0); adv();
        rst = 1'b0;
        bus.wr_lock_0 = 1'b0;
        req(1, 1'b0, 7'd0, 8'h77);
        settle(); chk("t5_grant", {30'd0, grant}, 32'd0); chk("t5_o1", {24'd0, o1}, 32'd0); adv();
        settle(); chk("t5_p0_first", {31'd0, bus.wr_ready_0}, 32'd1); adv(); drop(0);
        run_drop(4);

        // Owner drops valid while locked
        req(0, 1'b1, 7'd0, 8'h5A);
        cyc();
        settle(); chk("t6_ready", {31'd0, bus.wr_ready_0}, 32'd1); adv(); drop(0);
        settle(); chk("t6_grant_hold", {30'd0, grant}, 32'd1); adv();
        req(0, 1'b0, 7'd3, 8'hA1); req(1, 1'b0, 7'd4, 8'hB2);
        settle(); chk("t6_grant_idle", {30'd0, grant}, 32'd0); adv();
        settle(); chk("t6_p1_wins", {31'd0, bus.wr_ready_1}, 32'd1); chk("t6_p0_waits", {31'd0, bus.wr_ready_0}, 32'd0); adv();
        drop(1);
        run_drop(4);

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom % 100) == 0;
            for (int p = 0; p < 2; p++) begin
                logic v;
                v = (p == 0) ? bus.wr_valid_0 : bus.wr_valid_1;
                if (!v || rdy_seen[p]) begin
                    if (($urandom % 4) != 0)
                        req(p, 1'($urandom % 2),
                            (($urandom % 8) < 6) ? 7'($urandom % 5) : 7'($urandom_range(127, 5)),
                            8'($urandom));
                    else
                        drop(p);
                end
            end
            cyc();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
